async_fifo_core: RTL and testbench

ASYNC_FIFO_CORE -- requirements
Module: async_fifo_core

---
 rtl/async_fifo_core_pkg.sv | 18 +
 rtl/async_fifo_core_mem.sv | 27 ++
 rtl/async_fifo_core.sv | 116 +++++++++++
 tb/tb_async_fifo_core.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_core_pkg.sv
// Shared definitions for the single-clock FWFT FIFO slice.
// Holds legal parameter ranges and pointer/counter width helpers.
package async_fifo_core_pkg;

    localparam int SCALE_MIN  = 1;
    localparam int SCALE_MAX  = 16;
    localparam int THRESH_MIN = 1;

    function automatic int ptr_w(input int scale);
        return scale;
    endfunction

    // One extra bit so a completely full FIFO is representable.
    function automatic int cnt_w(input int scale);
        return scale + 1;
    endfunction

endpackage

// File: rtl/async_fifo_core_mem.sv
// DEPTH x WIDTH storage: synchronous write port, asynchronous read port.
// Ports: clk, we, waddr, wdata (write side); raddr -> rdata (combinational read).
module async_fifo_core_mem
    import async_fifo_core_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int WIDTH  = 30
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/async_fifo_core.sv
// Single-clock first-word-fall-through FIFO with registered status flags.
// Ports: clk, rst (sync, active-high); enqueue/wdata/full (write side);
// dequeue/rdata/empty (read side); filled (occupancy >= FILLED_THRESH).
// Build macro ASYNC_FIFO_CORE_ERR_EN adds sticky ovf/udf error outputs.
module async_fifo_core
    import async_fifo_core_pkg::*;
#(
    parameter int SIZE_SCALE    = 12,
    parameter int WIDTH         = 30,
    parameter int FILLED_THRESH = 2**10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enqueue,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    input  logic             dequeue,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             filled
`ifdef ASYNC_FIFO_CORE_ERR_EN
    ,
    output logic             ovf,
    output logic             udf
`endif
);

    localparam int PW    = ptr_w(SIZE_SCALE);
    localparam int CW    = cnt_w(SIZE_SCALE);
    localparam int DEPTH = 1 << SIZE_SCALE;

    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] THR_C  = CW'(FILLED_THRESH);

    if (SIZE_SCALE < SCALE_MIN || SIZE_SCALE > SCALE_MAX) begin : g_bad_scale
        $error("async_fifo_core: SIZE_SCALE out of range");
    end

    if (FILLED_THRESH < THRESH_MIN || FILLED_THRESH > DEPTH) begin : g_bad_thresh
        $error("async_fifo_core: FILLED_THRESH out of range");
    end

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          do_wr;
    logic          do_rd;

    // Flags are registered, so they already describe the current occupancy.
    always_comb begin
        do_wr = enqueue & ~full;
        do_rd = dequeue & ~empty;
    end

    always_comb begin
        cnt_nxt = cnt;
        unique case ({do_wr, do_rd})
            2'b10:   cnt_nxt = cnt + 1'b1;
            2'b01:   cnt_nxt = cnt - 1'b1;
            default: cnt_nxt = cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr   <= '0;
            rptr   <= '0;
            cnt    <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            filled <= 1'b0;
        end else begin
            if (do_wr) begin
                wptr <= wptr + 1'b1;
            end
            if (do_rd) begin
                rptr <= rptr + 1'b1;
            end
            cnt    <= cnt_nxt;
            full   <= (cnt_nxt == FULL_C);
            empty  <= (cnt_nxt == '0);
            filled <= (cnt_nxt >= THR_C);
        end
    end

`ifdef ASYNC_FIFO_CORE_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (enqueue & full) begin
                ovf <= 1'b1;
            end
            if (dequeue & empty) begin
                udf <= 1'b1;
            end
        end
    end
`endif

    // A write in the reset cycle must not land in storage either.
    async_fifo_core_mem #(
        .ADDR_W (PW),
        .WIDTH  (WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (do_wr & ~rst),
        .waddr (wptr),
        .wdata (wdata),
        .raddr (rptr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_async_fifo_core.sv
// Directed + random bench for async_fifo_core against a queue model.
// Define ASYNC_FIFO_CORE_ERR_EN to also check the ovf/udf outputs.
module tb_async_fifo_core;

    localparam int SS    = 2;
    localparam int W     = 8;
    localparam int TH    = 2;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enq = 1'b0;
    logic         deq = 1'b0;
    logic [W-1:0] wdata = '0;
    logic [W-1:0] rdata;
    logic         full;
    logic         empty;
    logic         filled;
`ifdef ASYNC_FIFO_CORE_ERR_EN
    logic         ovf;
    logic         udf;
    bit           m_ovf = 1'b0;
    bit           m_udf = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] q[$];

    always #5 clk = ~clk;

    async_fifo_core #(
        .SIZE_SCALE    (SS),
        .WIDTH         (W),
        .FILLED_THRESH (TH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enqueue (enq),
        .wdata   (wdata),
        .full    (full),
        .dequeue (deq),
        .rdata   (rdata),
        .empty   (empty),
        .filled  (filled)
`ifdef ASYNC_FIFO_CORE_ERR_EN
        ,
        .ovf     (ovf),
        .udf     (udf)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
        chk({tag, ".filled"}, 32'(filled), 32'(q.size() >= TH));
        if (q.size() != 0) begin
            chk({tag, ".rdata"}, 32'(rdata), 32'(q[0]));
        end
`ifdef ASYNC_FIFO_CORE_ERR_EN
        chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
        chk({tag, ".udf"}, 32'(udf), 32'(m_udf));
`endif
    endtask

    // Drive one cycle, advance the model at the edge, settle past the edge.
    task automatic step(input bit e, input bit d, input logic [W-1:0] w,
                        input bit r = 1'b0);
        bit wr;
        bit rd;
        enq   = e;
        deq   = d;
        wdata = w;
        rst   = r;
        @(posedge clk);
        if (r) begin
            q.delete();
`ifdef ASYNC_FIFO_CORE_ERR_EN
            m_ovf = 1'b0;
            m_udf = 1'b0;
`endif
        end else begin
            wr = e && (q.size() < DEPTH);
            rd = d && (q.size() > 0);
`ifdef ASYNC_FIFO_CORE_ERR_EN
            if (e && q.size() == DEPTH) m_ovf = 1'b1;
            if (d && q.size() == 0) m_udf = 1'b1;
`endif
            if (rd) void'(q.pop_front());
            if (wr) q.push_back(w);
        end
        #1;
        enq = 1'b0;
        deq = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        int k;
        int nin;
        int nout;

        // Reset and idle
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);
        check_all("reset");
        chk("reset.empty_c", 32'(empty), 32'd1);
        step(0, 0, '0);
        check_all("idle");

        // Two words in, two out
        step(1, 0, 8'h11);
        check_all("w11");
        chk("w11.rdata_c", 32'(rdata), 32'h11);
        step(1, 0, 8'h22);
        check_all("w22");
        chk("w22.filled_c", 32'(filled), 32'd1);
        step(0, 1, '0);
        check_all("r1");
        chk("r1.rdata_c", 32'(rdata), 32'h22);
        step(0, 1, '0);
        check_all("r2");
        chk("r2.empty_c", 32'(empty), 32'd1);

        // Fill, overflow attempt, drain
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 0, 8'(8'hA0 + i));
            check_all("fillA");
        end
        chk("fillA.full_c", 32'(full), 32'd1);
        step(1, 0, 8'hFF);
        check_all("ovf_try");
`ifdef ASYNC_FIFO_CORE_ERR_EN
        chk("ovf_c", 32'(ovf), 32'd1);
`endif
        k = 0;
        while (!empty && k < 8) begin
            chk("drainA", 32'(rdata), 32'(8'hA0 + k));
            step(0, 1, '0);
            check_all("drainA");
            k++;
        end
        chk("drainA.count", 32'(k), 32'd4);
        step(0, 1, '0);
        check_all("udf_try");

        // Simultaneous push/pop at full and at empty
        step(0, 0, '0, 1);
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 0, 8'(8'hB0 + i));
        end
        check_all("fullB");
        step(1, 1, 8'hCC);
        check_all("both_full");
        chk("both_full.full_c", 32'(full), 32'd0);
        chk("both_full.occ", 32'(q.size()), 32'd3);
        for (int i = 0; i < 3; i++) step(0, 1, '0);
        check_all("drainB");
        chk("drainB.empty_c", 32'(empty), 32'd1);
        step(1, 1, 8'hDD);
        check_all("both_empty");
        chk("both_empty.rdata_c", 32'(rdata), 32'hDD);
        step(0, 1, '0);

        // Continuous streaming across wraps
        nin = 0;
        nout = 0;
        for (int c = 0; c < 100 && nout < 20; c++) begin
            bit e;
            bit d;
            e = (nin < 20) && (q.size() < DEPTH);
            d = (q.size() > 0);
            if (d) begin
                chk("stream", 32'(rdata), 32'(nout));
                nout++;
            end
            step(e, d, 8'(nin));
            check_all("stream");
            if (e) nin++;
        end
        chk("stream.count", 32'(nout), 32'd20);

        // Reset with data stored
        for (int i = 0; i < 3; i++) step(1, 0, 8'(8'hE0 + i));
        step(1, 1, 8'hEE, 1);
        check_all("rst_mid");
        chk("rst_mid.empty_c", 32'(empty), 32'd1);
        step(1, 0, 8'h5A);
        check_all("post_rst");
        chk("post_rst.rdata_c", 32'(rdata), 32'h5A);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom), 1'($urandom_range(0, 60) == 0));
            check_all("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
